// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

  localparam int SUB_WIDTH_DEF = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, bout is the borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock; WIDTH+1 cycles per result.
// Optional signed-overflow output is enabled by SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,output logic            overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic             bit_d, bit_bout, last;
  logic [WIDTH-1:0] res;

  full_subtractor u_fs (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .bin  (bin_q),
    .diff (bit_d),
    .bout (bit_bout)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    res            = sr_q >> 1;
    res[WIDTH-1]   = bit_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sr_d     = sr_q;
    diff_d   = diff_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sr_d  = res;
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        bin_d = bit_bout;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          diff_d   = res;
          borrow_d = bit_bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // Operands have been shifted down, so bit 0 now holds the original MSBs.
          ovf_d    = (opa_q[0] ^ opb_q[0]) & (bit_d ^ opa_q[0]);
`endif
          state_d  = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      sr_q     <= '0;
      diff_q   <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sr_q     <= sr_d;
      diff_q   <= diff_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy   = (state_q == ST_RUN);
  assign done   = (state_q == ST_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1 instances).
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n, start, s1;
  logic [7:0] a, b, diff;
  logic       busy, done, borrow;
  logic [0:0] a1, b1, d1;
  logic       busy1, done1, bor1;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       ovf, ovf1;
`endif

  int checks = 0;
  int passed = 0;

  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] d; logic br; logic ov; } vec_t;
  typedef struct { logic [7:0] d; logic br; logic ov; } exp_t;
  typedef struct { logic a; logic b; logic d; logic br; logic ov; } vec1_t;

  vec_t  tbl[10];
  vec1_t tbl1[4];
  exp_t  sbq[$];

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,.overflow(ovf)
`endif
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .diff(d1), .borrow(bor1)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,.overflow(ovf1)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) begin
        checks++;
        $display("FAIL busy_done_overlap: busy=%0b done=%0b", busy, done);
      end
      if (done) begin
        if (sbq.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: diff=%0h with empty scoreboard", diff);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_diff", diff, e.d);
          chk("sb_borrow", borrow, e.br);
`ifdef SERIAL_SUB_OVERFLOW_EN
          chk("sb_overflow", ovf, e.ov);
`endif
        end
      end
    end
  end

  task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input exp_t e);
    int lat;
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 8);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("diff_held", diff, e.d);
  endtask

  task automatic count_dones(input int ncyc, output int n);
    n = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (done) n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, cyc;
    int   t[3];
    exp_t e;

    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{8'h10, 8'h20, 8'hF0, 1'b1, 1'b0};
    tbl[5] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[6] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[7] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    tbl[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b1};
    tbl[9] = '{8'hA5, 8'h5A, 8'h4B, 1'b0, 1'b1};

    tbl1[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl1[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl1[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl1[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    s1 = 1'b0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    chk("rst_w1_diff", d1, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    chk("rst_overflow", ovf, 0);
`endif
    rst_n = 1'b1;

    // Table-driven single operations
    for (int i = 0; i < 10; i++) begin
      e = '{tbl[i].d, tbl[i].br, tbl[i].ov};
      run_op(tbl[i].a, tbl[i].b, e);
    end

    // start during RUN is ignored
    @(negedge clk);
    a = 8'h05; b = 8'h03; start = 1'b1;
    sbq.push_back('{8'h02, 1'b0, 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h30; b = 8'h10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_dones(20, n);
    chk("ignore_start_single_done", n, 1);
    chk("ignore_start_sb_empty", sbq.size(), 0);

    // Reset mid-RUN aborts; previous diff=02 must clear immediately
    @(negedge clk);
    a = 8'h12; b = 8'h34; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_borrow", borrow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(15, n);
    chk("abort_no_done", n, 0);
    run_op(8'hFF, 8'hFF, '{8'h00, 1'b0, 1'b0});

    // Back-to-back with start held high
    for (int i = 0; i < 3; i++) sbq.push_back('{8'hF0, 1'b1, 1'b0});
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        t[n] = cyc;
        n++;
        if (n == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b_count", n, 3);
    if (n == 3) begin
      chk("b2b_first", t[0], 9);
      chk("b2b_gap0", t[1] - t[0], 9);
      chk("b2b_gap1", t[2] - t[1], 9);
    end
    count_dones(15, n);
    chk("b2b_no_extra", n, 0);
    chk("b2b_sb_empty", sbq.size(), 0);

    // WIDTH=1: registered half subtractor, one RUN cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a1 = tbl1[i].a; b1 = tbl1[i].b; s1 = 1'b1;
      @(negedge clk);
      s1 = 1'b0;
      chk("w1_busy", busy1, 1);
      chk("w1_not_done", done1, 0);
      @(negedge clk);
      chk("w1_done", done1, 1);
      chk("w1_diff", d1, tbl1[i].d);
      chk("w1_borrow", bor1, tbl1[i].br);
`ifdef SERIAL_SUB_OVERFLOW_EN
      chk("w1_overflow", ovf1, tbl1[i].ov);
`endif
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
